// File: rtl/hs_sync_pkg.sv
// Shared types and limits for the handshake pulse synchronizer endpoint.
// TX channel state encoding and the minimum synchronizer depth live here.
`timescale 1ns/1ps
package hs_sync_pkg;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_REQ  = 2'd1,
    TX_REL  = 2'd2
  } tx_state_t;

  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
// The output is the last flop of the chain, so it is always a registered level.
`timescale 1ns/1ps
module cdc_sync_bit
  import hs_sync_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  if (STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
    $error("cdc_sync_bit: STAGES must be at least %0d", SYNC_STAGES_MIN);
  end

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/hs_pulse_sync_endpoint.sv
// NCH-channel endpoint of a 4-phase req/ack pulse synchronizer (TX and RX halves).
// Define HS_PENDING_EN to add a 1-deep pending event per TX channel.
`timescale 1ns/1ps
module hs_pulse_sync_endpoint
  import hs_sync_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [NCH-1:0] tx_pulse,
  output logic [NCH-1:0] tx_busy,
  output logic [NCH-1:0] tx_drop,
  output logic [NCH-1:0] tx_req,
  input  logic [NCH-1:0] tx_ack_async,
  input  logic [NCH-1:0] rx_req_async,
  output logic [NCH-1:0] rx_ack,
  output logic [NCH-1:0] rx_pulse
);

  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
    $error("hs_pulse_sync_endpoint: SYNC_STAGES must be at least %0d", SYNC_STAGES_MIN);
  end
  if (NCH < 1) begin : g_bad_nch
    $error("hs_pulse_sync_endpoint: NCH must be at least 1");
  end

  // Handshake: req rises to announce one event and holds until the synchronized
  // ack is seen high; req then falls and the channel stays busy until ack falls.
  // Each side only ever looks at the other's registered level through a sync chain.
  logic [NCH-1:0] ack_s;
  logic [NCH-1:0] req_s;

  assign rx_ack = req_s;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    tx_state_t state_q;
    logic      req_q;
    logic      busy_q;
    logic      drop_q;
    logic      req_s_q;
    logic      pulse_q;

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (tx_ack_async[ch]),
      .q       (ack_s[ch])
    );

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (rx_req_async[ch]),
      .q       (req_s[ch])
    );

`ifdef HS_PENDING_EN
    logic pend_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= TX_IDLE;
        req_q   <= 1'b0;
        busy_q  <= 1'b0;
        drop_q  <= 1'b0;
        pend_q  <= 1'b0;
      end else begin
        drop_q <= 1'b0;
        case (state_q)
          TX_IDLE: begin
            if (tx_pulse[ch]) begin
              state_q <= TX_REQ;
              req_q   <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
          TX_REQ: begin
            if (ack_s[ch]) begin
              state_q <= TX_REL;
              req_q   <= 1'b0;
            end
            if (tx_pulse[ch]) begin
              if (pend_q) drop_q <= 1'b1;
              else        pend_q <= 1'b1;
            end
          end
          TX_REL: begin
            if (!ack_s[ch]) begin
              // A stored or simultaneous event relaunches without visiting idle;
              // with both present the new pulse takes the freed pending slot.
              if (pend_q || tx_pulse[ch]) begin
                state_q <= TX_REQ;
                req_q   <= 1'b1;
                pend_q  <= pend_q & tx_pulse[ch];
              end else begin
                state_q <= TX_IDLE;
                busy_q  <= 1'b0;
              end
            end else if (tx_pulse[ch]) begin
              if (pend_q) drop_q <= 1'b1;
              else        pend_q <= 1'b1;
            end
          end
          default: begin
            state_q <= TX_IDLE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            pend_q  <= 1'b0;
          end
        endcase
      end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= TX_IDLE;
        req_q   <= 1'b0;
        busy_q  <= 1'b0;
        drop_q  <= 1'b0;
      end else begin
        drop_q <= tx_pulse[ch] & busy_q;
        case (state_q)
          TX_IDLE: begin
            if (tx_pulse[ch]) begin
              state_q <= TX_REQ;
              req_q   <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
          TX_REQ: begin
            if (ack_s[ch]) begin
              state_q <= TX_REL;
              req_q   <= 1'b0;
            end
          end
          TX_REL: begin
            if (!ack_s[ch]) begin
              state_q <= TX_IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= TX_IDLE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
`endif

    // Rising edge of the synchronized req is the reconstructed remote event.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        req_s_q <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        req_s_q <= req_s[ch];
        pulse_q <= req_s[ch] & ~req_s_q;
      end
    end

    assign tx_req[ch]   = req_q;
    assign tx_busy[ch]  = busy_q;
    assign tx_drop[ch]  = drop_q;
    assign rx_pulse[ch] = pulse_q;
  end

endmodule
